// File: rtl/studio_keypad_pkg.sv
// Shared scan-code map and defaults for the Studio II / VIP keypad controller.
// map_scan() turns a non-extended PS/2 set-2 code into {valid, pad, key}.
package studio_keypad_pkg;

  localparam logic [2:0] SEL_PORT_DEFAULT = 3'd2;

  // Pad 0: main-row digits 0..9 then letters a..f
  localparam logic [7:0] SC_PAD0 [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

  // Pad 1: numeric keypad digits 0..9
  localparam logic [7:0] SC_PAD1 [10] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  typedef struct packed {
    logic       valid;
    logic [1:0] pad;
    logic [3:0] key;
  } key_map_t;

  function automatic key_map_t map_scan(input logic [7:0] code);
    key_map_t m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (code == SC_PAD0[i]) begin
        m.valid = 1'b1;
        m.pad   = 2'd0;
        m.key   = 4'(i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (code == SC_PAD1[i]) begin
        m.valid = 1'b1;
        m.pad   = 2'd1;
        m.key   = 4'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/studio_keypad_ctrl_if.sv
// CPU OUT-instruction bus seen by the keypad controller (strobe, N lines, data).
interface studio_keypad_ctrl_if;
  logic       io_out;
  logic [2:0] io_n;
  logic [7:0] io_dout;

  modport master (output io_out, io_n, io_dout);
  modport slave  (input  io_out, io_n, io_dout);
endinterface

// File: rtl/keypad_hold_timer.sv
// Per-key press stretcher: defers a release until HOLD_CYCLES after the last press.
// clr is a combinational pulse telling the owner to drop the key bit on this edge.
module keypad_hold_timer #(
  parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic resetq,
  input  logic press,
  input  logic rel,
  output logic clr
);

  logic [15:0] cnt;
  logic        pend;

  // A release arriving with the count at 0 or 1 clears on the same edge it would have expired
  assign clr = !press && ((rel && cnt <= 16'd1) || (pend && cnt == 16'd1));

  always_ff @(posedge clk) begin
    if (!resetq) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else if (press) begin
      cnt  <= HOLD_CYCLES;
      pend <= 1'b0;
    end else begin
      if (cnt != 16'd0) cnt <= cnt - 16'd1;
      if (clr)      pend <= 1'b0;
      else if (rel) pend <= 1'b1;
    end
  end

endmodule

// File: rtl/studio_keypad_ctrl.sv
// Multi-pad hex keypad controller: PS/2 + parallel keys -> one EF flag per pad.
// Optional press stretching under KEYPAD_HOLD_EN (uses keypad_hold_timer).
module studio_keypad_ctrl
  import studio_keypad_pkg::*;
#(
  parameter int          NUM_PADS    = 2,
  parameter int          KEY_BITS    = 4,
  parameter logic [2:0]  SEL_PORT    = SEL_PORT_DEFAULT,
  parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
  input  logic                                clk,
  input  logic                                resetq,
  studio_keypad_ctrl_if.slave                 cpu,
  input  logic [10:0]                         ps2_key,
  input  logic [NUM_PADS*(2**KEY_BITS)-1:0]   ext_keys,
  output logic [NUM_PADS-1:0]                 ef_out,
  output logic [KEY_BITS-1:0]                 key_sel,
  output logic [NUM_PADS*(2**KEY_BITS)-1:0]   key_state
);

  localparam int NK    = 2**KEY_BITS;
  localparam int NKEYS = NUM_PADS * NK;

  logic             tog_q;
  logic             ps2_ev;
  key_map_t         km;
  logic [NKEYS-1:0] press_hit;
  logic [NKEYS-1:0] rel_hit;
  logic [NKEYS-1:0] clr_vec;

  always_comb begin
    ps2_ev    = (ps2_key[10] != tog_q) && !ps2_key[8];
    km        = map_scan(ps2_key[7:0]);
    press_hit = '0;
    rel_hit   = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (ps2_ev && km.valid && int'(km.pad) < NUM_PADS && int'(km.key) < NK &&
          i == int'(km.pad) * NK + int'(km.key)) begin
        press_hit[i] = ps2_key[9];
        rel_hit[i]   = !ps2_key[9];
      end
    end
  end

`ifdef KEYPAD_HOLD_EN
  for (genvar g = 0; g < NKEYS; g++) begin : g_hold
    keypad_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
      .clk    (clk),
      .resetq (resetq),
      .press  (press_hit[g]),
      .rel    (rel_hit[g]),
      .clr    (clr_vec[g])
    );
  end
`else
  assign clr_vec = rel_hit;
  // HOLD_CYCLES only matters in hold builds; kept so both builds share one parameter list
  if (HOLD_CYCLES == 16'd0) begin : g_hold_param_unused
  end
`endif

  if (KEY_BITS < 8) begin : g_dout_unused
    logic unused_dout;
    assign unused_dout = ^cpu.io_dout[7:KEY_BITS];
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      tog_q     <= ps2_key[10];
      key_state <= '0;
      key_sel   <= '0;
      ef_out    <= '0;
    end else begin
      tog_q     <= ps2_key[10];
      key_state <= (key_state | press_hit) & ~clr_vec;
      if (cpu.io_out && cpu.io_n == SEL_PORT)
        key_sel <= cpu.io_dout[KEY_BITS-1:0];
      for (int p = 0; p < NUM_PADS; p++)
        ef_out[p] <= key_state[p*NK + int'(key_sel)] | ext_keys[p*NK + int'(key_sel)];
    end
  end

endmodule

// File: tb/tb_studio_keypad_ctrl.sv
// Directed bench for studio_keypad_ctrl: vector table plus latency/reset/hold sequences.
module tb_studio_keypad_ctrl;

  logic        clk = 1'b0;
  logic        resetq;
  logic [10:0] ps2_key;
  logic [31:0] ext_keys;
  logic [1:0]  ef_out;
  logic [3:0]  key_sel;
  logic [31:0] key_state;

  always #5 clk = ~clk;

  studio_keypad_ctrl_if bus ();

  studio_keypad_ctrl #(
    .NUM_PADS    (2),
    .KEY_BITS    (4),
    .SEL_PORT    (3'd2),
    .HOLD_CYCLES (16'd8)
  ) dut (
    .clk       (clk),
    .resetq    (resetq),
    .cpu       (bus.slave),
    .ps2_key   (ps2_key),
    .ext_keys  (ext_keys),
    .ef_out    (ef_out),
    .key_sel   (key_sel),
    .key_state (key_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        ps2;
    logic        pr;
    logic        ex;
    logic [7:0]  code;
    logic        outv;
    logic [2:0]  n;
    logic [7:0]  d;
    logic [31:0] ext;
    logic [3:0]  e_sel;
    logic [31:0] e_ks;
    logic [1:0]  e_ef;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_evt(input logic pr, input logic ex, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ex, code};
  endtask

  task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
    bus.io_out  = 1'b1;
    bus.io_n    = n;
    bus.io_dout = d;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    tick(1);
    resetq = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h05, 32'h0,         4'h5, 32'h0000_0000, 2'b00};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 8'h2E, 1'b0, 3'd0, 8'h00, 32'h0,         4'h5, 32'h0000_0020, 2'b01};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h17, 32'h0,         4'h7, 32'h0000_0020, 2'b00};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 8'h73, 1'b0, 3'd0, 8'h00, 32'h0,         4'h7, 32'h0020_0020, 2'b00};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h05, 32'h0,         4'h5, 32'h0020_0020, 2'b11};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8'h2E, 1'b0, 3'd0, 8'h00, 32'h0,         4'h5, 32'h0020_0000, 2'b10};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 8'h70, 1'b0, 3'd0, 8'h00, 32'h0,         4'h5, 32'h0020_0000, 2'b10};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 8'h1A, 1'b0, 3'd0, 8'h00, 32'h0,         4'h5, 32'h0020_0000, 2'b10};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 8'h09, 32'h0,         4'h5, 32'h0020_0000, 2'b10};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h73, 1'b0, 3'd0, 8'h00, 32'h0,         4'h5, 32'h0000_0000, 2'b00};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 32'h0020_0000, 4'h5, 32'h0000_0000, 2'b10};
    vt[11] = '{1'b1, 1'b1, 1'b0, 8'h24, 1'b1, 3'd2, 8'h0E, 32'h0,         4'hE, 32'h0000_4000, 2'b01};
    vt[12] = '{1'b1, 1'b1, 1'b0, 8'h24, 1'b0, 3'd0, 8'h00, 32'h0,         4'hE, 32'h0000_4000, 2'b01};
    vt[13] = '{1'b1, 1'b1, 1'b0, 8'h7D, 1'b0, 3'd0, 8'h00, 32'h0,         4'hE, 32'h0200_4000, 2'b01};
    vt[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h19, 32'h0,         4'h9, 32'h0200_4000, 2'b10};
    vt[15] = '{1'b1, 1'b0, 1'b0, 8'h24, 1'b0, 3'd0, 8'h00, 32'h0,         4'h9, 32'h0200_0000, 2'b10};
    vt[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 32'h0000_0200, 4'h9, 32'h0200_0000, 2'b11};
    vt[17] = '{1'b1, 1'b0, 1'b0, 8'h7D, 1'b0, 3'd0, 8'h00, 32'h0,         4'h9, 32'h0000_0000, 2'b00};

    resetq      = 1'b0;
    ps2_key     = '0;
    ext_keys    = '0;
    bus.io_out  = 1'b0;
    bus.io_n    = '0;
    bus.io_dout = '0;
    tick(2);
    resetq = 1'b1;
    check("reset key_state", key_state, 32'h0);
    check("reset key_sel", 32'(key_sel), 32'h0);
    check("reset ef_out", 32'(ef_out), 32'h0);

    // Latency: key_sel one edge after OUT; key_state one edge, ef two edges after the event
    cpu_out(3'd2, 8'h05);
    tick(1);
    bus.io_out = 1'b0;
    check("lat sel", 32'(key_sel), 32'h5);
    ps2_evt(1'b1, 1'b0, 8'h2E);
    tick(1);
    check("lat ks edge1", key_state, 32'h0000_0020);
    check("lat ef edge1", 32'(ef_out), 32'h0);
    tick(1);
    check("lat ef edge2", 32'(ef_out), 32'h1);
    cpu_out(3'd2, 8'h17);
    tick(1);
    bus.io_out = 1'b0;
    check("lat sel 7", 32'(key_sel), 32'h7);
    ps2_evt(1'b1, 1'b0, 8'h73);
    tick(2);
    check("lat ef sel7", 32'(ef_out), 32'h0);
    cpu_out(3'd2, 8'h05);
    tick(1);
    bus.io_out = 1'b0;
    check("lat ef before", 32'(ef_out), 32'h0);
    tick(1);
    check("lat ef after out", 32'(ef_out), 32'h3);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      ext_keys = vt[i].ext;
      if (vt[i].ps2) ps2_evt(vt[i].pr, vt[i].ex, vt[i].code);
      if (vt[i].outv) cpu_out(vt[i].n, vt[i].d);
      tick(1);
      bus.io_out = 1'b0;
      tick(11);
      check($sformatf("vec%0d key_sel", i), 32'(key_sel), 32'(vt[i].e_sel));
      check($sformatf("vec%0d key_state", i), key_state, vt[i].e_ks);
      check($sformatf("vec%0d ef_out", i), 32'(ef_out), 32'(vt[i].e_ef));
    end

    // Simultaneous event and OUT, then reset mid-press while the toggle flips
    do_reset();
    ext_keys = '0;
    ps2_evt(1'b1, 1'b0, 8'h45);
    cpu_out(3'd2, 8'h00);
    tick(1);
    bus.io_out = 1'b0;
    check("sim ks", key_state, 32'h0000_0001);
    tick(1);
    check("sim ef", 32'(ef_out), 32'h1);
    resetq = 1'b0;
    ps2_evt(1'b1, 1'b0, 8'h16);
    tick(1);
    resetq = 1'b1;
    check("rst ks", key_state, 32'h0);
    check("rst sel", 32'(key_sel), 32'h0);
    check("rst ef", 32'(ef_out), 32'h0);
    tick(3);
    check("post rst ks", key_state, 32'h0);
    check("post rst ef", 32'(ef_out), 32'h0);

    // Short tap: release two edges after the press
    do_reset();
    ps2_evt(1'b1, 1'b0, 8'h16);
    for (int e = 1; e <= 10; e++) begin
      logic exp_bit;
      tick(1);
`ifdef KEYPAD_HOLD_EN
      exp_bit = (e <= 8);
`else
      exp_bit = (e <= 2);
`endif
      check($sformatf("tap edge%0d", e), 32'(key_state[1]), 32'(exp_bit));
      if (e == 2) ps2_evt(1'b0, 1'b0, 8'h16);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/studio_keypad_ctrl.md
Name: studio_keypad_ctrl

Overview:
- Generalised keypad controller for the Studio II / VIP family core.
- Tracks a configurable number of hex keypads, fed from two sources:
  - PS/2 scan-code events;
  - a parallel joystick/OSD key vector.
- Latches the key number the CPU writes with an OUT instruction.
- Drives one EF flag per keypad: flag = "selected key is down on that pad". This replaces the single hard-wired keypad and input bit in the top level.

Parameters:
- NUM_PADS, 2, number of keypads; each pad drives one EF flag (range 1..4).
- KEY_BITS, 4, key index width; each pad has 2**KEY_BITS keys (4 gives hex pad, 0x0-0xF).
- SEL_PORT, 3'd2, N-line value of the OUT instruction that loads the key select latch.
- HOLD_CYCLES, 16'd50000, minimum press stretch in clk cycles (used only with KEYPAD_HOLD_EN).

Ports:
- clk  in  1  system clock
- resetq  in  1  synchronous reset, active-low
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scan code
- ext_keys  in  NUM_PADS*2**KEY_BITS  level key inputs, pad p key k at bit p*2**KEY_BITS+k
- io_out  in  1  CPU OUT strobe, one cycle
- io_n  in  3  CPU N lines
- io_dout  in  8  CPU output data
- ef_out  out  NUM_PADS  ef_out[p] = selected key of pad p is down
- key_sel  out  KEY_BITS  current select latch
- key_state  out  NUM_PADS*2**KEY_BITS  debounced/held PS/2 key state, for debug and OSD

Behaviour:
- Reset (resetq=0 at a clk edge):
  - key_state, key_sel and ef_out all go to 0.
  - The internal toggle register loads ps2_key[10], so no spurious event occurs on release.
  - Reset mid-press drops every held key.
- PS/2 event detect:
  - An event is a cycle where ps2_key[10] differs from the registered copy; the copy then updates.
  - Events with ps2_key[8]=1 are ignored.
- PS/2 key map, non-extended codes only:
  - Pad 0: main-row digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 = keys 0..9; 0x1C,0x32,0x21,0x23,0x24,0x2B = keys A..F (a,b,c,d,e,f).
  - Pad 1: numpad 0x70,0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D = keys 0..9; no A..F.
  - Pads >= 2 have no PS/2 mapping and use ext_keys only.
  - Keys >= 2**KEY_BITS are dropped.
  - Unmapped codes are ignored.
- Key state update:
  - Press event sets the key bit; release clears it.
  - Takes effect on the edge after the event (1-cycle latency).
  - Repeated press of a held key: no change.
- Select latch:
  - io_out=1 and io_n==SEL_PORT loads key_sel <= io_dout[KEY_BITS-1:0].
  - Upper data bits are ignored. Other N values are ignored.
- EF generation:
  - Registered: ef_out[p] <= key_state[p][key_sel] | ext_keys[p][key_sel].
  - Total latency: 1 cycle from a key_sel/key_state change, and 2 cycles from the PS/2 event edge.
- Simultaneous PS/2 event and OUT in the same cycle: both update; ef_out reflects both one cycle later.
- ext_keys is sampled directly, with no synchroniser (same clock domain).
- Multiple keys held on one pad: all tracked independently; the EF flag depends only on the selected key.

Optional Feature:
- Macro KEYPAD_HOLD_EN.
- When defined:
  - Each PS/2 key has a countdown loaded with HOLD_CYCLES on press.
  - A release event while the count is nonzero is deferred: the bit clears when the count reaches 0.
  - A re-press during a deferred release reloads the counter and cancels the pending clear.
  - Counters reset to 0.
  - Purpose: a short host tap is still seen by the 60 Hz CPU poll loop.
- When undefined: release clears immediately, no counters exist, and HOLD_CYCLES is unused.

Decomposition:
- Package studio_keypad_pkg holds:
  - the scan-code constants;
  - a function mapping {scan code} -> {valid, pad, key};
  - the OUT port constant default.
- One sub-module, keypad_hold_timer:
  - one counter plus a pending-release flag per key;
  - instantiated NUM_PADS*2**KEY_BITS times in a generate loop under KEYPAD_HOLD_EN.

Test Plan:
- Reset then OUT N=2 data 0x05, PS/2 press 0x2E (toggle) -> key_state bit5 = 1; ef_out[0]=1 two cycles after the event; ef_out[1]=0.
- OUT N=2 data 0x17, numpad 0x73 pressed -> key_sel=7, ef_out[1]=0. Then OUT 0x05 -> ef_out[1]=1 one cycle after the OUT.
- Extended event 0xE0-flagged 0x70 press, and unmapped 0x1A press -> key_state unchanged, ef_out stays 0.
- OUT with io_n=3 data 0x09 -> key_sel unchanged. ext_keys bit (pad1,key sel) high -> ef_out[1]=1 one cycle later.
- PS/2 press 0x45 and OUT 0x00 on the same cycle, then reset low for one edge mid-press -> ef_out[0]=1 after one cycle, then all outputs 0 and no event on the next toggle-stable cycle.
- KEYPAD_HOLD_EN, HOLD_CYCLES=8: press 0x16 then release 2 cycles later -> bit1 stays set until 8 cycles after the press, then clears. Without the macro it clears on the release edge.
